// File: rtl/l2_arbiter_if.sv
// rtl/l2_arbiter_if.sv - L1/L2 request and response bundle for the L2 arbiter
interface l2_arbiter_if;
  // I-cache side
  logic         i_read;
  logic [15:0]  i_address;
  logic         i_resp;
  logic [127:0] i_rdata;
  // D-cache side
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic         d_resp;
  logic [127:0] d_rdata;
  // L2 side
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  mem_address;
  logic [127:0] l2_wdata;
  logic         l2_resp;
  logic [127:0] l2_mem_rdata;

  // Arbiter view: takes L1 requests and L2 responses, drives the rest.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
    input  l2_resp, l2_mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
    output l2_read, l2_write, mem_address, l2_wdata
  );

  // Environment view: the L1 caches and the L2 controller.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
    output l2_resp, l2_mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  l2_read, l2_write, mem_address, l2_wdata
  );
endinterface

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - two-port I/D to L2 arbiter; L2_ARB_RR_EN selects round-robin over fixed D priority
module l2_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  l2_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  state_t       r_state;
  logic         r_owner;        // 0 = I-cache, 1 = D-cache
  logic         r_l2_read;
  logic         r_l2_write;
  logic         r_i_resp;
  logic         r_d_resp;
  logic [15:0]  r_mem_address;
  logic [127:0] r_l2_wdata;
  logic [127:0] r_ret_data;

`ifdef L2_ARB_RR_EN
  logic         r_last_grant;   // 0 = I last won, 1 = D last won
`endif

  logic         w_i_req;
  logic         w_d_req;
  logic         w_grant_d;
  logic         w_d_wr;

  assign w_i_req = bus.i_read;
  assign w_d_req = bus.d_read | bus.d_write;
  // A D request with both read and write high is treated as a writeback.
  assign w_d_wr  = w_grant_d & bus.d_write;

  // Pick the winner among the current requests (only acted on in IDLE).
  always_comb begin
    w_grant_d = 1'b0;
    if (w_i_req && w_d_req) begin
`ifdef L2_ARB_RR_EN
      w_grant_d = ~r_last_grant;
`else
      w_grant_d = 1'b1;
`endif
    end else begin
      w_grant_d = w_d_req;
    end
  end

  // Arbiter FSM with registered L2 request and L1 response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_l2_read     <= 1'b0;
      r_l2_write    <= 1'b0;
      r_i_resp      <= 1'b0;
      r_d_resp      <= 1'b0;
      r_mem_address <= 16'h0000;
      r_l2_wdata    <= '0;
      r_ret_data    <= '0;
`ifdef L2_ARB_RR_EN
      r_last_grant  <= 1'b0;
`endif
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            r_owner       <= w_grant_d;
            r_mem_address <= w_grant_d ? bus.d_address : bus.i_address;
            if (w_d_wr) begin
              r_l2_wdata <= bus.d_wdata;
            end
            r_l2_read     <= ~w_d_wr;
            r_l2_write    <= w_d_wr;
            r_state       <= w_grant_d ? D_BUSY : I_BUSY;
`ifdef L2_ARB_RR_EN
            r_last_grant  <= w_grant_d;
`endif
          end
        end
        I_BUSY, D_BUSY: begin
          // L1 inputs are ignored here; address and write line stay latched.
          if (bus.l2_resp) begin
            r_ret_data <= bus.l2_mem_rdata;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            r_i_resp   <= ~r_owner;
            r_d_resp   <= r_owner;
            r_state    <= RESP;
          end
        end
        RESP: begin
          // The L1 drops its request after seeing resp, so never re-grant here.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.l2_read     = r_l2_read;
  assign bus.l2_write    = r_l2_write;
  assign bus.mem_address = r_mem_address;
  assign bus.l2_wdata    = r_l2_wdata;
  assign bus.i_resp      = r_i_resp;
  assign bus.d_resp      = r_d_resp;
  assign bus.i_rdata     = r_ret_data;
  assign bus.d_rdata     = r_ret_data;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - self-checking bench for l2_arbiter with a transaction-level reference model
module tb_l2_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_arbiter_if bus();

  l2_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: who won last, and the write line L2 should see.
  bit           m_last  = 1'b0;
  logic [127:0] m_wdata = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_l2_read"},  128'(bus.l2_read),  128'(0));
    chk({tag, "_l2_write"}, 128'(bus.l2_write), 128'(0));
    chk({tag, "_i_resp"},   128'(bus.i_resp),   128'(0));
    chk({tag, "_d_resp"},   128'(bus.d_resp),   128'(0));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full grant: predict winner from the request rules, run L2 with the
  // given latency, check the response, drop the winner's request.
  task automatic serve(input int lat, input logic [127:0] rdat, input bit scramble, input bit inject);
    bit          w;
    bit          wr;
    bit          i_req;
    bit          d_req;
    logic [15:0] addr;
    i_req = bus.i_read;
    d_req = bus.d_read | bus.d_write;
    if (i_req && d_req) begin
`ifdef L2_ARB_RR_EN
      w = ~m_last;
`else
      w = 1'b1;
`endif
    end else begin
      w = d_req;
    end
    m_last = w;
    wr     = w & bus.d_write;
    addr   = w ? bus.d_address : bus.i_address;
    if (wr) m_wdata = bus.d_wdata;
    tick;
    for (int k = 0; k < lat; k++) begin
      chk("busy_l2_read",  128'(bus.l2_read),     128'(!wr));
      chk("busy_l2_write", 128'(bus.l2_write),    128'(wr));
      chk("busy_addr",     128'(bus.mem_address), 128'(addr));
      chk("busy_wdata",    bus.l2_wdata,          m_wdata);
      chk("busy_i_resp",   128'(bus.i_resp),      128'(0));
      chk("busy_d_resp",   128'(bus.d_resp),      128'(0));
      if (scramble) begin
        bus.i_address = 16'($urandom);
        bus.d_address = 16'($urandom);
        bus.d_wdata   = rnd128();
      end
      if (k == lat - 1) begin
        bus.l2_resp      = 1'b1;
        bus.l2_mem_rdata = rdat;
      end
      tick;
    end
    bus.l2_resp      = 1'b0;
    bus.l2_mem_rdata = rnd128();
    chk("resp_i_resp",   128'(bus.i_resp),   128'(!w));
    chk("resp_d_resp",   128'(bus.d_resp),   128'(w));
    chk("resp_l2_read",  128'(bus.l2_read),  128'(0));
    chk("resp_l2_write", 128'(bus.l2_write), 128'(0));
    if (!wr) chk("resp_rdata", w ? bus.d_rdata : bus.i_rdata, rdat);
    if (w) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read  = 1'b0;
    end
    if (inject) begin
      bus.d_read    = 1'b1;
      bus.d_address = 16'($urandom);
    end
    tick;
    chk_idle("post_resp");
  endtask

  task automatic drain;
    for (int n = 0; n < 4; n++) begin
      if (bus.i_read | bus.d_read | bus.d_write)
        serve($urandom_range(1, 4), rnd128(), 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.i_read       = 1'b0;
    bus.i_address    = '0;
    bus.d_read       = 1'b0;
    bus.d_write      = 1'b0;
    bus.d_address    = '0;
    bus.d_wdata      = '0;
    bus.l2_resp      = 1'b0;
    bus.l2_mem_rdata = '0;

    // Reset state
    tick;
    tick;
    chk_idle("rst");
    chk("rst_addr",    128'(bus.mem_address), 128'(0));
    chk("rst_wdata",   bus.l2_wdata,          128'(0));
    chk("rst_i_rdata", bus.i_rdata,           128'(0));
    chk("rst_d_rdata", bus.d_rdata,           128'(0));
    rst_n = 1'b1;
    tick;
    chk_idle("idle_noreq");

    // Single I read, L2 latency 3
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1234;
    serve(3, {16{8'hA5}}, 1'b0, 1'b0);

    // D writeback
    bus.d_write   = 1'b1;
    bus.d_address = 16'h8F30;
    bus.d_wdata   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    serve(4, rnd128(), 1'b0, 1'b0);

    // Conflict with busy-time input churn; loser served right after RESP
    bus.i_read    = 1'b1;
    bus.i_address = 16'h1111;
    bus.d_read    = 1'b1;
    bus.d_address = 16'h2222;
    serve(2, rnd128(), 1'b1, 1'b0);
    serve(3, rnd128(), 1'b1, 1'b0);

    // Lone D grant, then a read+write conflict
    bus.d_read    = 1'b1;
    bus.d_address = 16'h3333;
    serve(1, rnd128(), 1'b0, 1'b0);
    bus.i_read    = 1'b1;
    bus.i_address = 16'h4444;
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 16'h5555;
    bus.d_wdata   = rnd128();
    serve(2, rnd128(), 1'b0, 1'b0);
    drain;

    // Three consecutive conflicts
    for (int n = 0; n < 3; n++) begin
      bus.i_read    = 1'b1;
      bus.d_read    = 1'b1;
      bus.d_address = 16'($urandom);
      serve(2, rnd128(), 1'b0, 1'b0);
    end
    drain;

    // D request raised during RESP must wait for IDLE
    bus.i_read    = 1'b1;
    bus.i_address = 16'h6666;
    serve(2, rnd128(), 1'b0, 1'b1);
    drain;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      bus.i_read    = ($urandom_range(0, 1) == 1);
      bus.d_read    = ($urandom_range(0, 2) == 0);
      bus.d_write   = ($urandom_range(0, 2) == 0);
      bus.i_address = 16'($urandom);
      bus.d_address = 16'($urandom);
      bus.d_wdata   = rnd128();
      if (!(bus.i_read | bus.d_read | bus.d_write)) begin
        tick;
        chk_idle("rand_idle");
      end else begin
        serve($urandom_range(1, 5), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain;
      end
    end

    // Reset during D_BUSY: write drops asynchronously, no resp afterwards
    bus.d_write   = 1'b1;
    bus.d_address = 16'h7777;
    bus.d_wdata   = rnd128();
    tick;
    chk("mid_l2_write_before", 128'(bus.l2_write), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_l2_write_async", 128'(bus.l2_write), 128'(0));
    chk("mid_l2_read_async",  128'(bus.l2_read),  128'(0));
    bus.l2_resp = 1'b1;
    tick;
    bus.l2_resp = 1'b0;
    rst_n       = 1'b1;
    bus.d_write = 1'b0;
    m_last      = 1'b0;
    m_wdata     = '0;
    for (int n = 0; n < 4; n++) begin
      tick;
      chk_idle("post_rst");
    end
    chk("post_rst_wdata", bus.l2_wdata, m_wdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
